wall_follower_fsm: RTL and testbench

- Robot-side controller for the world/robot sensor–actuator interface.
- Consumes the four sensor bits the world drives each cycle (head, left, under, barrier).
- Produces one action per clock (front, turn, remove), following a left-hand wall rule.
- Clears removable barriers with the 3-cycle remove handshake; halts when under is seen.

---
 rtl/robot_pkg.sv | 10 +
 rtl/wall_follower_cnt.sv | 21 ++
 rtl/wall_follower_fsm.sv | 128 ++++++++++++
 tb/tb_wall_follower_fsm.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/robot_pkg.sv
// robot_pkg: shared state, orientation codes and default constants for the robot controller
package robot_pkg;
  typedef enum logic [2:0] {SEEK, FOLLOW, LEFT_GO, REMOVE, ROTATE, HALT} state_t;
  typedef enum logic [1:0] {N = 2'b00, S = 2'b01, E = 2'b10, W = 2'b11} orient_t;
  localparam int REMOVE_CYCLES_DEF = 3;
  localparam int RIGHT_TURNS_DEF   = 3;
  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/wall_follower_cnt.sv
// wall_follower_cnt: loadable down-counter with zero flag, shared by remove and rotate sequencing
module wall_follower_cnt #(
  parameter int W = 2
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic         i_dec,
  input  logic [W-1:0] i_val,
  output logic [W-1:0] o_cnt,
  output logic         o_zero
);
  logic [W-1:0] r_cnt;
  // load wins over decrement; decrement stops at zero
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_cnt <= '0;
    else if (i_load) r_cnt <= i_val;
    else if (i_dec && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
  assign o_cnt  = r_cnt;
  assign o_zero = (r_cnt == '0);
endmodule

// File: rtl/wall_follower_fsm.sv
// wall_follower_fsm: left-hand wall-following robot controller; STEP_LIMIT_EN adds a front-move limit and step_count
module wall_follower_fsm
  import robot_pkg::*;
#(
  parameter int REMOVE_CYCLES = REMOVE_CYCLES_DEF,
  parameter int RIGHT_TURNS   = RIGHT_TURNS_DEF
`ifdef STEP_LIMIT_EN
  , parameter int MAX_STEPS   = 1023
`endif
) (
  input  logic clock,
  input  logic reset,
  input  logic head,
  input  logic left,
  input  logic under,
  input  logic barrier,
  output logic front,
  output logic turn,
  output logic remove,
`ifdef STEP_LIMIT_EN
  output logic halted,
  output logic [$clog2(MAX_STEPS+1)-1:0] step_count
`else
  output logic halted
`endif
);
  localparam int CW = $clog2(max2(max2(REMOVE_CYCLES, RIGHT_TURNS), 2));
  state_t r_state, r_ret, w_next, w_ret;
  logic r_front, r_turn, r_remove, r_halted;
  logic w_front, w_turn, w_remove, w_halted, w_load, w_dec, w_zero;
  logic [CW-1:0] w_val, w_cnt;
`ifdef STEP_LIMIT_EN
  localparam int SW = $clog2(MAX_STEPS+1);
  logic [SW-1:0] r_step;
  wire w_limit = (r_step == SW'(MAX_STEPS));
`endif
  wall_follower_cnt #(.W(CW)) u_cnt (
    .i_clk(clock), .i_rst_n(reset), .i_load(w_load), .i_dec(w_dec),
    .i_val(w_val), .o_cnt(w_cnt), .o_zero(w_zero)
  );
  // decision priority: halt, barrier removal, then the per-state wall rule
  always_comb begin
    w_next = r_state;
    w_ret = r_ret;
    w_front = 1'b0;
    w_turn = 1'b0;
    w_remove = 1'b0;
    w_halted = 1'b0;
    w_load = 1'b0;
    w_dec = 1'b0;
    w_val = '0;
    case (r_state)
      HALT: w_halted = 1'b1;
      REMOVE: begin
        w_remove = !w_zero;
        w_dec = !w_zero;
        w_next = w_zero ? r_ret : REMOVE;
      end
      ROTATE: begin
        w_turn = 1'b1;
        w_dec = 1'b1;
        w_next = (w_cnt <= CW'(1)) ? FOLLOW : ROTATE;
      end
      default:
        if (under) begin
          w_next = HALT;
          w_halted = 1'b1;
        end else if (barrier) begin
          w_next = REMOVE;
          w_ret = r_state;
          w_remove = 1'b1;
          w_load = 1'b1;
          w_val = CW'(REMOVE_CYCLES - 1);
        end else if (r_state == SEEK && left) w_next = FOLLOW;
        else if (r_state == FOLLOW && !left) begin
          w_turn = 1'b1;
          w_next = LEFT_GO;
        end else if (!head) begin
          w_front = 1'b1;
          w_next = (r_state == LEFT_GO) ? FOLLOW : r_state;
        end else begin
          w_turn = 1'b1;
          w_next = (RIGHT_TURNS > 1) ? ROTATE : FOLLOW;
          w_load = 1'b1;
          w_val = CW'(RIGHT_TURNS - 1);
        end
    endcase
`ifdef STEP_LIMIT_EN
    if (w_limit) begin
      w_next = HALT;
      w_front = 1'b0;
      w_turn = 1'b0;
      w_remove = 1'b0;
      w_halted = 1'b1;
      w_load = 1'b0;
      w_dec = 1'b0;
    end
`endif
  end
  // state and registered action outputs
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      r_state <= SEEK;
      r_ret <= SEEK;
      r_front <= 1'b0;
      r_turn <= 1'b0;
      r_remove <= 1'b0;
      r_halted <= 1'b0;
    end else begin
      r_state <= w_next;
      r_ret <= w_ret;
      r_front <= w_front;
      r_turn <= w_turn;
      r_remove <= w_remove;
      r_halted <= w_halted;
    end
`ifdef STEP_LIMIT_EN
  // step count moves together with each registered front
  always_ff @(posedge clock or negedge reset)
    if (!reset) r_step <= '0;
    else if (w_front && !w_limit) r_step <= r_step + 1'b1;
  assign step_count = r_step;
`endif
  assign front  = r_front;
  assign turn   = r_turn;
  assign remove = r_remove;
  assign halted = r_halted;
endmodule

// File: tb/tb_wall_follower_fsm.sv
// tb_wall_follower_fsm: directed and randomized checks of wall_follower_fsm against an action-queue model
module tb_wall_follower_fsm;
`ifdef STEP_LIMIT_EN
  localparam int MAXS = 4;
`else
  localparam int MAXS = 1023;
`endif
  localparam int RC = 3;
  localparam int RT = 3;
  localparam byte AF = "F";
  localparam byte AT = "T";
  localparam byte AR = "R";
  localparam byte AH = "H";
  localparam byte A0 = "0";
  logic clock, reset, head, left, under, barrier;
  logic front, turn, remove, halted;
  int nvec = 0;
  int errs = 0;
  byte m_q[$];
  int m_mode;
  bit m_halt;
  int m_steps;
  int exp_bits;
`ifdef STEP_LIMIT_EN
  logic [2:0] step_count;
  wall_follower_fsm #(.MAX_STEPS(MAXS)) dut (
    .clock(clock), .reset(reset), .head(head), .left(left), .under(under), .barrier(barrier),
    .front(front), .turn(turn), .remove(remove), .halted(halted), .step_count(step_count)
  );
`else
  wall_follower_fsm dut (
    .clock(clock), .reset(reset), .head(head), .left(left), .under(under), .barrier(barrier),
    .front(front), .turn(turn), .remove(remove), .halted(halted)
  );
`endif
  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic int bits_of(input byte a);
    return (a == AF) ? 1 : (a == AT) ? 2 : (a == AR) ? 4 : (a == AH) ? 8 : 0;
  endfunction

  function automatic int dut_bits();
    return int'({halted, remove, turn, front});
  endfunction

  function automatic int hexv(input byte c);
    return (c >= "a") ? int'(c) - 87 : int'(c) - 48;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // mode 0 = seeking a wall, 1 = following, 2 = just stepped into a left opening
  task automatic model_step(input logic h, input logic l, input logic u, input logic b);
    byte a;
    a = A0;
    if (m_halt) a = AH;
    else if (m_steps == MAXS) begin a = AH; m_halt = 1; end
    else if (m_q.size() > 0) a = m_q.pop_front();
    else if (u) begin a = AH; m_halt = 1; end
    else if (b) begin
      a = AR;
      repeat (RC - 1) m_q.push_back(AR);
      m_q.push_back(A0);
    end else if (m_mode == 0 && l) m_mode = 1;
    else if (m_mode == 1 && !l) begin a = AT; m_mode = 2; end
    else if (!h) begin a = AF; if (m_mode == 2) m_mode = 1; end
    else begin
      a = AT;
      repeat (RT - 1) m_q.push_back(AT);
      m_mode = 1;
    end
    if (a == AF && m_steps < MAXS) m_steps++;
    exp_bits = bits_of(a);
  endtask

  task automatic tick(input logic h, input logic l, input logic u, input logic b);
    head = h; left = l; under = u; barrier = b;
    model_step(h, l, u, b);
    @(posedge clock);
    #1;
    chk("cycle", dut_bits(), exp_bits);
`ifdef STEP_LIMIT_EN
    chk("step_count", int'(step_count), m_steps);
`endif
  endtask

  task automatic do_reset();
    #2 reset = 1'b0;
    #1;
    chk("async_reset", dut_bits(), 0);
    m_q.delete();
    m_mode = 0;
    m_halt = 0;
    m_steps = 0;
    @(negedge clock);
    reset = 1'b1;
  endtask

  // stim: one hex digit per cycle {head,left,under,barrier}; ex: one action letter per cycle
  task automatic seq(input string name, input string st, input string ex);
    for (int i = 0; i < st.len(); i++) begin
      int v;
      v = hexv(st[i]);
      tick(v[3], v[2], v[1], v[0]);
      chk({name, "_model"}, exp_bits, bits_of(ex[i]));
      chk({name, "_dut"}, dut_bits(), bits_of(ex[i]));
    end
  endtask

  initial begin
    reset = 1'b1;
    head = 0; left = 0; under = 0; barrier = 0;
    m_mode = 0; m_halt = 0; m_steps = 0; exp_bits = 0;
    do_reset();
`ifdef STEP_LIMIT_EN
    seq("open_field", "00000", "FFFFH");
`else
    seq("open_field", "00000", "FFFFF");
`endif
    do_reset();
    seq("seek_right", "8884", "TTTF");
    do_reset();
    seq("left_go", "4000", "0TFT");
    do_reset();
    seq("remove", "11100", "RRR0F");
    do_reset();
    seq("halt", "3", "H");
    for (int i = 0; i < 20; i++) begin
      tick(1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)), 1'b0);
      chk("halt_hold", dut_bits(), 8);
    end
    do_reset();
    seq("after_halt", "0", "F");
    do_reset();
    seq("mid_rotate", "8", "T");
    do_reset();
    seq("post_abort", "0", "F");
    for (int e = 0; e < 8; e++) begin
      do_reset();
      for (int c = 0; c < 150; c++) begin
        logic u, b, h, l;
        u = ($urandom_range(99) < 2);
        b = ($urandom_range(7) == 0);
        h = b ? 1'b0 : 1'($urandom_range(1));
        l = 1'($urandom_range(1));
        tick(h, l, u, b);
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
    $finish;
  end
endmodule
